// File: rtl/pic_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pic_ctrl
// Brief    : Bus sequencer for an 8259 PIC: init writes, INTA handshake,
//            vector hand-off to the CPU and coalesced non-specific EOI.
// Revision : 1.0
// ============================================================================
module pic_ctrl #(
  parameter logic [7:0]  ICW2_BASE = 8'h08,
  parameter logic [7:0]  IMR_INIT  = 8'h00,
  parameter int unsigned PULSE_LEN = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pic_cs_n,
  output logic       pic_wr_n,
  output logic       pic_rd_n,
  output logic       pic_a0,
  output logic       pic_inta_n,
  output logic [7:0] pic_dout,
  input  logic [7:0] pic_din,
  input  logic       pic_int,
  input  logic       cpu_ie,
  output logic       irq_valid,
  output logic [7:0] irq_vector,
  input  logic       irq_ack,
  input  logic       eoi_req,
  output logic       eoi_done,
  output logic       init_done
);

  localparam logic [3:0] c_init_icw1 = 4'd0;
  localparam logic [3:0] c_init_icw2 = 4'd1;
  localparam logic [3:0] c_init_icw4 = 4'd2;
  localparam logic [3:0] c_init_ocw1 = 4'd3;
  localparam logic [3:0] c_idle      = 4'd4;
  localparam logic [3:0] c_inta1     = 4'd5;
  localparam logic [3:0] c_inta_gap  = 4'd6;
  localparam logic [3:0] c_inta2     = 4'd7;
  localparam logic [3:0] c_present   = 4'd8;
  localparam logic [3:0] c_eoi_wr    = 4'd9;

  localparam logic [4:0] c_plen = 5'(PULSE_LEN);
  localparam logic [4:0] c_hold = 5'(PULSE_LEN + 2);

  logic [3:0] r_state;
  logic [3:0] w_state_nxt;
  logic [4:0] r_cnt;
  logic [4:0] w_cnt_nxt;
  logic       r_eoi_pend;
  logic       r_init_done;
  logic [7:0] r_vector;
  logic       w_is_wr_state;
  logic       w_wr_active;
  logic       w_wr_last;
  logic       w_eoi_done;
  logic       w_eoi_pend;
  logic [7:0] w_wr_data;
  logic       w_wr_a0;

  // In write states, r_cnt==0 is the idle gap (cs_n high); 1 is setup,
  // 2..PULSE_LEN+1 is the wr_n pulse and PULSE_LEN+2 is the hold cycle.
  always_comb begin
    w_is_wr_state = 1'b1;
    w_wr_data     = 8'h00;
    w_wr_a0       = 1'b0;
    case (r_state)
      c_init_icw1: w_wr_data = 8'h13;
      c_init_icw2: begin w_wr_data = ICW2_BASE; w_wr_a0 = 1'b1; end
      c_init_icw4: begin w_wr_data = 8'h09;     w_wr_a0 = 1'b1; end
      c_init_ocw1: begin w_wr_data = IMR_INIT;  w_wr_a0 = 1'b1; end
      c_eoi_wr:    w_wr_data = 8'h20;
      default:     w_is_wr_state = 1'b0;
    endcase
  end

  assign w_wr_active = w_is_wr_state && (r_cnt != 5'd0);
  assign w_wr_last   = w_wr_active && (r_cnt == c_hold);
  assign w_eoi_done  = (r_state == c_eoi_wr) && w_wr_last;
  assign w_eoi_pend  = r_eoi_pend | eoi_req;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      c_init_icw1, c_init_icw2, c_init_icw4, c_init_ocw1, c_eoi_wr: begin
        if (w_wr_last) begin
          w_cnt_nxt = 5'd0;
          case (r_state)
            c_init_icw1: w_state_nxt = c_init_icw2;
            c_init_icw2: w_state_nxt = c_init_icw4;
            c_init_icw4: w_state_nxt = c_init_ocw1;
            default:     w_state_nxt = c_idle;
          endcase
        end else begin
          w_cnt_nxt = r_cnt + 5'd1;
        end
      end
      c_idle: begin
        // EOI is entered straight at setup; no gap needed after IDLE
        if (w_eoi_pend) begin
          w_state_nxt = c_eoi_wr;
          w_cnt_nxt   = 5'd1;
        end else if (pic_int && cpu_ie) begin
          w_state_nxt = c_inta1;
          w_cnt_nxt   = 5'd1;
        end
      end
      c_inta1: begin
        if (r_cnt == c_plen) begin
          w_state_nxt = c_inta_gap;
          w_cnt_nxt   = 5'd1;
        end else begin
          w_cnt_nxt = r_cnt + 5'd1;
        end
      end
      c_inta_gap: begin
        if (r_cnt == 5'd2) begin
          w_state_nxt = c_inta2;
          w_cnt_nxt   = 5'd1;
        end else begin
          w_cnt_nxt = r_cnt + 5'd1;
        end
      end
      c_inta2: begin
        if (r_cnt == c_plen) begin
          w_state_nxt = c_present;
          w_cnt_nxt   = 5'd0;
        end else begin
          w_cnt_nxt = r_cnt + 5'd1;
        end
      end
      c_present: begin
        if (irq_ack) begin
          w_state_nxt = c_idle;
          w_cnt_nxt   = 5'd0;
        end
      end
      default: begin
        w_state_nxt = c_init_icw1;
        w_cnt_nxt   = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_init_icw1;
      r_cnt       <= 5'd0;
      r_eoi_pend  <= 1'b0;
      r_init_done <= 1'b0;
      r_vector    <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      // A request landing on the completion cycle survives for another write
      r_eoi_pend <= eoi_req | (r_eoi_pend & ~w_eoi_done);
      if ((r_state == c_init_ocw1) && w_wr_last) begin
        r_init_done <= 1'b1;
      end
      if ((r_state == c_inta2) && (r_cnt == c_plen)) begin
        r_vector <= pic_din;
      end
    end
  end

  assign pic_cs_n   = ~(w_wr_active || (r_state == c_inta2));
  assign pic_wr_n   = ~(w_wr_active && (r_cnt != 5'd1) && (r_cnt != c_hold));
  assign pic_rd_n   = ~(r_state == c_inta2);
  assign pic_inta_n = ~((r_state == c_inta1) || (r_state == c_inta2));
  assign pic_a0     = w_wr_active & w_wr_a0;
  assign pic_dout   = w_wr_active ? w_wr_data : 8'h00;
  assign irq_valid  = (r_state == c_present);
  assign irq_vector = r_vector;
  assign eoi_done   = w_eoi_done;
  assign init_done  = r_init_done;

endmodule
`default_nettype wire
